// File: rtl/s_read_fetcher.sv
// s_read_fetcher: S-bus read master. Streams word_cnt words starting at
// base_addr into a local FIFO and presents them on a valid/ready stream.
// Requests are only issued while outstanding + buffered words leave room in
// the FIFO, so returned data can always be accepted.
module s_read_fetcher #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_STEP  = 8
) (
    input  logic              Sclk,
    input  logic              Sreset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       word_cnt,
    output logic              busy,
    output logic              done,
    output logic              Srrequest,
    input  logic              Srack,
    output logic [ADDR_W-1:0] Sraddr,
    input  logic              Srstrobe,
    input  logic [DATA_W-1:0] Srdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              BAD
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       remaining;
    logic [15:0]       job_cnt;
    logic [15:0]       pop_cnt;
    logic [CNT_W-1:0]  outstanding;
    logic [CNT_W-1:0]  fifo_count;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic              bad;

    logic [CNT_W:0]    inflight;
    logic              have_credit;
    logic              start_ok;
    logic              accept;
    logic              stb_ok;
    logic              stb_err;
    logic              pop;

    // Credit uses registered counts only. Since the sum only grows on an
    // accept, a raised request cannot lose its credit before Srack.
    assign inflight    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign have_credit = inflight < DEPTH_C;
    assign start_ok    = (state == S_IDLE) && start;
    assign Srrequest   = (state == S_ISSUE) && have_credit;
    assign accept      = Srrequest && Srack;
    assign stb_ok      = Srstrobe && (outstanding != '0);
    assign stb_err     = Srstrobe && (outstanding == '0);
    assign out_valid   = (fifo_count != '0);
    assign pop         = out_valid && out_ready;

    assign Sraddr   = addr;
    assign busy     = (state == S_ISSUE) || (state == S_DRAIN);
    assign done     = (state == S_DONE);
    assign out_data = mem[rd_ptr];
    assign out_last = out_valid && (pop_cnt == job_cnt - 16'd1);
    assign BAD      = bad;

    // Job sequencing: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
    always_ff @(posedge Sclk or negedge Sreset) begin
        if (!Sreset) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state <= (word_cnt == 16'd0) ? S_DONE : S_ISSUE;
                S_ISSUE: if (accept && remaining == 16'd1) state <= S_DRAIN;
                S_DRAIN: if (outstanding == '0 && fifo_count == '0 && pop_cnt == job_cnt)
                             state <= S_DONE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Request address, job counters and the sticky protocol-error flag.
    always_ff @(posedge Sclk or negedge Sreset) begin
        if (!Sreset) begin
            addr      <= '0;
            remaining <= '0;
            job_cnt   <= '0;
            pop_cnt   <= '0;
            bad       <= 1'b0;
        end else begin
            if (start_ok) begin
                addr      <= base_addr;
                remaining <= word_cnt;
                job_cnt   <= word_cnt;
            end else if (accept) begin
                addr      <= addr + ADDR_W'(ADDR_STEP);
                remaining <= remaining - 16'd1;
            end
            if (start_ok)
                pop_cnt <= '0;
            else if (pop)
                pop_cnt <= pop_cnt + 16'd1;
            if (start_ok)
                bad <= 1'b0;
            else if (stb_err)
                bad <= 1'b1;
        end
    end

    // Outstanding requests, FIFO occupancy and pointers.
    always_ff @(posedge Sclk or negedge Sreset) begin
        if (!Sreset) begin
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            case ({accept, stb_ok})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
            case ({stb_ok, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (stb_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge Sclk) begin
        if (stb_ok) mem[wr_ptr] <= Srdata;
    end

endmodule

// File: tb/tb_s_read_fetcher.sv
// Testbench for s_read_fetcher: table-driven basic job plus directed
// sequences for backpressure, zero length, ignored start, wrap, errors, reset.
module tb_s_read_fetcher;

    logic        Sclk, Sreset, start, Srack, Srstrobe, out_ready;
    logic [31:0] base_addr, Sraddr;
    logic [15:0] word_cnt;
    logic [63:0] Srdata, out_data;
    logic        busy, done, Srrequest, out_valid, out_last, BAD;

    s_read_fetcher #(.ADDR_W(32), .DATA_W(64), .FIFO_DEPTH(8), .ADDR_STEP(8)) dut (
        .Sclk(Sclk), .Sreset(Sreset), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .busy(busy), .done(done), .Srrequest(Srrequest),
        .Srack(Srack), .Sraddr(Sraddr), .Srstrobe(Srstrobe), .Srdata(Srdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .BAD(BAD)
    );

    initial begin
        Sclk = 1'b0;
        forever #5 Sclk = ~Sclk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct {
        logic        st;
        logic [31:0] base;
        logic [15:0] cnt;
        logic        ack;
        logic        stb;
        logic [63:0] sdata;
        logic        rdy;
        logic        e_busy;
        logic        e_done;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [63:0] e_data;
        logic        e_last;
        logic        e_bad;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] a;
    } rsp_t;

    vec_t        tbl[12];
    rsp_t        pend[$];
    bit          auto_rsp = 1'b0;
    int          lat = 3;
    logic [31:0] job_base;
    int          job_cnt, n_acc, n_pop, n_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] waddr(input int k);
        return job_base + 32'(k) * 32'd8;
    endfunction

    function automatic logic [63:0] wdata(input logic [31:0] a);
        return {32'hDA7A_0000, a};
    endfunction

    function automatic vec_t mkv(input logic st, input logic stb, input logic [63:0] sd,
                                 input logic eb, input logic ed, input logic er,
                                 input logic [31:0] ea, input logic ev,
                                 input logic [63:0] edat, input logic el);
        vec_t r;
        r.st = st; r.base = 32'h1000; r.cnt = 16'd4; r.ack = 1'b1;
        r.stb = stb; r.sdata = sd; r.rdy = 1'b1;
        r.e_busy = eb; r.e_done = ed; r.e_req = er; r.e_addr = ea;
        r.e_valid = ev; r.e_data = edat; r.e_last = el; r.e_bad = 1'b0;
        return r;
    endfunction

    // One clock cycle with the bench responder and scoreboard; starts and ends at negedge.
    task automatic run_cycle();
        if (auto_rsp) begin
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                Srstrobe = 1'b1;
                Srdata   = wdata(pend[0].a);
                void'(pend.pop_front());
            end else begin
                Srstrobe = 1'b0;
                Srdata   = '0;
            end
        end
        #1;
        if (Srrequest && Srack) begin
            chk("req_addr", Sraddr, waddr(n_acc));
            pend.push_back('{cyc + lat, waddr(n_acc)});
            n_acc++;
        end
        if (out_valid && out_ready) begin
            chk("pop_data", out_data, wdata(waddr(n_pop)));
            chk("pop_last", out_last, n_pop == job_cnt - 1);
            n_pop++;
        end
        if (done) n_done++;
        @(negedge Sclk);
        cyc++;
    endtask

    task automatic start_job(input logic [31:0] b, input int c);
        job_base = b; job_cnt = c;
        n_acc = 0; n_pop = 0; n_done = 0;
        start = 1'b1; base_addr = b; word_cnt = 16'(c);
        run_cycle();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && n_done == 0; i++) run_cycle();
        run_cycle();
        chk("done_pulses", 64'(n_done), 64'd1);
    endtask

    initial begin
        Sreset = 1'b0; start = 1'b0; Srack = 1'b0; Srstrobe = 1'b0; out_ready = 1'b0;
        base_addr = '0; word_cnt = '0; Srdata = '0;

        tbl[0]  = mkv(1, 0, 64'h0,                  0, 0, 0, 32'h0,    0, 64'h0, 0);
        tbl[1]  = mkv(0, 0, 64'h0,                  1, 0, 1, 32'h1000, 0, 64'h0, 0);
        tbl[2]  = mkv(0, 0, 64'h0,                  1, 0, 1, 32'h1008, 0, 64'h0, 0);
        tbl[3]  = mkv(0, 0, 64'h0,                  1, 0, 1, 32'h1010, 0, 64'h0, 0);
        tbl[4]  = mkv(0, 1, 64'hDA7A0000_00001000,  1, 0, 1, 32'h1018, 0, 64'h0, 0);
        tbl[5]  = mkv(0, 1, 64'hDA7A0000_00001008,  1, 0, 0, 32'h1020, 1, 64'hDA7A0000_00001000, 0);
        tbl[6]  = mkv(0, 1, 64'hDA7A0000_00001010,  1, 0, 0, 32'h1020, 1, 64'hDA7A0000_00001008, 0);
        tbl[7]  = mkv(0, 1, 64'hDA7A0000_00001018,  1, 0, 0, 32'h1020, 1, 64'hDA7A0000_00001010, 0);
        tbl[8]  = mkv(0, 0, 64'h0,                  1, 0, 0, 32'h1020, 1, 64'hDA7A0000_00001018, 1);
        tbl[9]  = mkv(0, 0, 64'h0,                  1, 0, 0, 32'h1020, 0, 64'h0, 0);
        tbl[10] = mkv(0, 0, 64'h0,                  0, 1, 0, 32'h1020, 0, 64'h0, 0);
        tbl[11] = mkv(0, 0, 64'h0,                  0, 0, 0, 32'h1020, 0, 64'h0, 0);

        // Reset held with random inputs
        @(negedge Sclk);
        for (int i = 0; i < 6; i++) begin
            start = 1'($urandom); Srack = 1'($urandom); Srstrobe = 1'($urandom);
            out_ready = 1'($urandom); base_addr = $urandom; word_cnt = 16'($urandom);
            Srdata = {$urandom, $urandom};
            #1;
            chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_req", Srrequest, 0);
            chk("rst_addr", Sraddr, 0); chk("rst_valid", out_valid, 0);
            chk("rst_last", out_last, 0); chk("rst_bad", BAD, 0);
            @(negedge Sclk); cyc++;
        end
        start = 0; Srack = 0; Srstrobe = 0; out_ready = 0; base_addr = '0; word_cnt = '0; Srdata = '0;
        Sreset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1; chk("post_rst_req", Srrequest, 0); chk("post_rst_busy", busy, 0);
            @(negedge Sclk); cyc++;
        end

        // Basic job from the vector table
        for (int i = 0; i < 12; i++) begin
            start = tbl[i].st; base_addr = tbl[i].base; word_cnt = tbl[i].cnt;
            Srack = tbl[i].ack; Srstrobe = tbl[i].stb; Srdata = tbl[i].sdata;
            out_ready = tbl[i].rdy;
            #1;
            chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
            chk($sformatf("v%0d_done", i), done, tbl[i].e_done);
            chk($sformatf("v%0d_req", i), Srrequest, tbl[i].e_req);
            chk($sformatf("v%0d_addr", i), Sraddr, tbl[i].e_addr);
            chk($sformatf("v%0d_valid", i), out_valid, tbl[i].e_valid);
            if (tbl[i].e_valid) chk($sformatf("v%0d_data", i), out_data, tbl[i].e_data);
            chk($sformatf("v%0d_last", i), out_last, tbl[i].e_last);
            chk($sformatf("v%0d_bad", i), BAD, tbl[i].e_bad);
            @(negedge Sclk); cyc++;
        end
        start = 0; Srstrobe = 0; Srdata = '0;

        // Zero-length job: done the cycle after start, no request
        start_job(32'h4000, 0);
        #1; chk("zero_done", done, 1); chk("zero_req", Srrequest, 0); chk("zero_busy", busy, 0);
        @(negedge Sclk); cyc++;
        #1; chk("zero_done_end", done, 0); chk("zero_req2", Srrequest, 0);
        @(negedge Sclk); cyc++;

        // Stray return in IDLE sets BAD; next start clears it
        Srstrobe = 1'b1; Srdata = 64'hBAD;
        run_cycle();
        Srstrobe = 1'b0; Srdata = '0;
        #1; chk("err_bad_set", BAD, 1); chk("err_dropped", out_valid, 0);
        @(negedge Sclk); cyc++;
        auto_rsp = 1'b1; lat = 2; Srack = 1'b1; out_ready = 1'b1;
        start_job(32'h5000, 1);
        #1; chk("err_bad_clear", BAD, 0);
        wait_done(50);
        chk("err_job_pops", 64'(n_pop), 64'd1); chk("err_job_bad", BAD, 0);

        // Backpressure: FIFO credit limits issue to 8
        out_ready = 1'b0;
        start_job(32'h2000, 20);
        repeat (15) run_cycle();
        chk("bp_acc8", 64'(n_acc), 64'd8);
        #1; chk("bp_req_low", Srrequest, 0); chk("bp_full_valid", out_valid, 1);
        out_ready = 1'b1;
        run_cycle();
        out_ready = 1'b0;
        repeat (8) run_cycle();
        chk("bp_acc9", 64'(n_acc), 64'd9);
        chk("bp_pop1", 64'(n_pop), 64'd1);
        out_ready = 1'b1;
        wait_done(200);
        chk("bp_pops", 64'(n_pop), 64'd20); chk("bp_bad", BAD, 0);

        // Start during ISSUE is ignored
        Srack = 1'b0;
        start_job(32'h3000, 3);
        run_cycle();
        start = 1'b1; base_addr = 32'h7000; word_cnt = 16'd9;
        run_cycle();
        start = 1'b0;
        #1; chk("ign_addr", Sraddr, 32'h3000); chk("ign_busy", busy, 1);
        Srack = 1'b1;
        wait_done(100);
        chk("ign_acc", 64'(n_acc), 64'd3); chk("ign_pops", 64'(n_pop), 64'd3);

        // Address wrap with a stalled ack
        Srack = 1'b0;
        start_job(32'hFFFF_FFF8, 2);
        for (int i = 0; i < 3; i++) begin
            #1; chk("wrap_hold_req", Srrequest, 1); chk("wrap_hold_addr", Sraddr, 32'hFFFF_FFF8);
            @(negedge Sclk); cyc++;
        end
        Srack = 1'b1;
        run_cycle();
        #1; chk("wrap_addr0", Sraddr, 32'h0); chk("wrap_req2", Srrequest, 1);
        wait_done(50);
        chk("wrap_pops", 64'(n_pop), 64'd2);

        // Reset mid-job, stale returns flag BAD, then a clean job
        lat = 3;
        start_job(32'h6000, 8);
        repeat (4) run_cycle();
        #2; Sreset = 1'b0;
        #1; chk("mid_rst_busy", busy, 0); chk("mid_rst_req", Srrequest, 0);
        chk("mid_rst_addr", Sraddr, 0); chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_done", done, 0); chk("mid_rst_last", out_last, 0);
        @(negedge Sclk); cyc++;
        Sreset = 1'b1;
        n_acc = 0; n_pop = 0;
        run_cycle();
        #1; chk("stale_bad", BAD, 1);
        @(negedge Sclk); cyc++;
        pend.delete();
        Srstrobe = 1'b0;
        start_job(32'h6100, 5);
        wait_done(100);
        chk("rec_pops", 64'(n_pop), 64'd5); chk("rec_acc", 64'(n_acc), 64'd5);
        chk("rec_bad", BAD, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
